// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: valid/ready pipeline register with flush, complement output and optional skid entry
module pipe_reg_skid #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit              SKID      = 1'b1
) (
    input  logic             Clk,
    input  logic             R,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [1:0]       occupancy
);
    logic [1:0] occ, occ_d;
    logic [WIDTH-1:0] q, skid_q;
    logic push, pop, clr, rdy;
    assign clr       = !R || flush;
    assign out_valid = occ != 2'd0;
    assign in_ready  = !clr && rdy;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occ_d     = occ + {1'b0, push} - {1'b0, pop};
    assign Q         = q;
    assign Qn        = ~q;
    assign occupancy = occ;
    always_ff @(posedge Clk) begin
        if (clr) begin
            occ <= 2'd0;
            q   <= RESET_VAL;
        end else begin
            occ <= occ_d;
            if (push && (occ == 2'd0 || pop)) q <= in_data;
            else if (pop && occ == 2'd2) q <= skid_q;
        end
    end
    generate
        if (SKID) begin : g_skid
            logic rdy_q;
            // Ready is precomputed from next occupancy so it never depends on out_ready
            always_ff @(posedge Clk) begin
                if (clr) begin
                    skid_q <= RESET_VAL;
                    rdy_q  <= 1'b1;
                end else begin
                    rdy_q <= occ_d != 2'd2;
                    if (push && !pop && occ == 2'd1) skid_q <= in_data;
                end
            end
            assign rdy = rdy_q;
        end else begin : g_pass
            assign skid_q = RESET_VAL;
            assign rdy    = !out_valid || out_ready;
        end
    endgenerate
endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb_pipe_reg_skid: scoreboard bench for skid (SKID=1) and pass-through (SKID=0) variants
module tb_pipe_reg_skid;
    logic Clk = 1'b0, R = 1'b0;
    logic flush1 = 0, iv1 = 0, or1 = 0, ir1, ov1;
    logic [31:0] id1 = 0, q1, qn1;
    logic [1:0] occ1;
    logic flush0 = 0, iv0 = 0, or0 = 0, ir0, ov0;
    logic [7:0] id0 = 0, q0, qn0;
    logic [1:0] occ0;
    logic [31:0] sb1[$];
    logic [7:0] sb0[$];
    int checks = 0, errors = 0;

    always #5 Clk = ~Clk;

    pipe_reg_skid #(.WIDTH(32), .RESET_VAL(32'h0000_00FF), .SKID(1'b1)) dut1 (
        .Clk(Clk), .R(R), .flush(flush1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .Q(q1), .Qn(qn1), .occupancy(occ1));

    pipe_reg_skid #(.WIDTH(8), .RESET_VAL(8'h5A), .SKID(1'b0)) dut0 (
        .Clk(Clk), .R(R), .flush(flush0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .Q(q0), .Qn(qn0), .occupancy(occ0));

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        R = 0; iv1 = 1; iv0 = 1;
        tick; tick;
        checks++; if (ir1 !== 1'b0) begin errors++; $display("FAIL reset_ir1 got %b exp 0", ir1); end
        checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL reset_ir0 got %b exp 0", ir0); end
        checks++; if (qn1 !== 32'hFFFF_FF00) begin errors++; $display("FAIL reset_qn_in_reset got %h exp ffffff00", qn1); end
        R = 1; iv1 = 0; iv0 = 0;
        #1;
        checks++; if (q1 !== 32'h0000_00FF) begin errors++; $display("FAIL reset_q1 got %h exp 000000ff", q1); end
        checks++; if (qn1 !== 32'hFFFF_FF00) begin errors++; $display("FAIL reset_qn1 got %h exp ffffff00", qn1); end
        checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin errors++; $display("FAIL reset_state1 got ov=%b occ=%0d exp ov=0 occ=0", ov1, occ1); end
        checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL reset_release_ir1 got %b exp 1", ir1); end
        checks++; if (q0 !== 8'h5A || qn0 !== 8'hA5 || ir0 !== 1'b1) begin errors++; $display("FAIL reset_dut0 got q=%h qn=%h ir=%b exp 5a a5 1", q0, qn0, ir0); end
    endtask

    task automatic test_streaming;
        logic [31:0] e;
        or1 = 1;
        for (int i = 1; i <= 4; i++) begin
            iv1 = 1; id1 = i; sb1.push_back(i);
            tick;
            e = sb1.pop_front();
            checks++; if (q1 !== e || ov1 !== 1'b1) begin errors++; $display("FAIL stream_q got %h ov=%b exp %h ov=1", q1, ov1, e); end
            checks++; if (occ1 !== 2'd1 || ir1 !== 1'b1) begin errors++; $display("FAIL stream_occ got occ=%0d ir=%b exp occ=1 ir=1", occ1, ir1); end
        end
        iv1 = 0;
        tick;
        checks++; if (occ1 !== 2'd0 || ov1 !== 1'b0) begin errors++; $display("FAIL stream_drain got occ=%0d ov=%b exp 0 0", occ1, ov1); end
        or1 = 0;
    endtask

    task automatic test_backpressure;
        or1 = 0; iv1 = 1; id1 = 32'hAAAA_0001;
        tick;
        id1 = 32'hBBBB_0002;
        tick;
        checks++; if (occ1 !== 2'd2 || ir1 !== 1'b0) begin errors++; $display("FAIL bp_full got occ=%0d ir=%b exp occ=2 ir=0", occ1, ir1); end
        id1 = 32'hCCCC_0003;
        tick;
        checks++; if (occ1 !== 2'd2 || q1 !== 32'hAAAA_0001) begin errors++; $display("FAIL bp_hold got occ=%0d q=%h exp occ=2 q=aaaa0001", occ1, q1); end
        iv1 = 0; or1 = 1;
        tick;
        checks++; if (q1 !== 32'hBBBB_0002 || occ1 !== 2'd1) begin errors++; $display("FAIL bp_pop_a got q=%h occ=%0d exp bbbb0002 1", q1, occ1); end
        checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", ir1); end
        tick;
        checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin errors++; $display("FAIL bp_empty got ov=%b occ=%0d exp 0 0", ov1, occ1); end
        checks++; if (q1 !== 32'hBBBB_0002) begin errors++; $display("FAIL bp_retain got %h exp bbbb0002", q1); end
        or1 = 0;
    endtask

    task automatic test_flush;
        or1 = 0; iv1 = 1; id1 = 32'h1111_1111;
        tick;
        id1 = 32'h2222_2222;
        tick;
        flush1 = 1; id1 = 32'h3333_3333; or1 = 1;
        #1;
        checks++; if (ir1 !== 1'b0) begin errors++; $display("FAIL flush_ir got %b exp 0", ir1); end
        tick;
        flush1 = 0; iv1 = 0; or1 = 0;
        checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0 || q1 !== 32'h0000_00FF) begin errors++; $display("FAIL flush_state got ov=%b occ=%0d q=%h exp 0 0 000000ff", ov1, occ1, q1); end
        tick;
        checks++; if (ov1 !== 1'b0 || ir1 !== 1'b1) begin errors++; $display("FAIL flush_no_c got ov=%b ir=%b exp 0 1", ov1, ir1); end
    endtask

    task automatic test_skid0;
        iv0 = 1; id0 = 8'h05; or0 = 0;
        tick;
        iv0 = 0;
        #1;
        checks++; if (ov0 !== 1'b1 || q0 !== 8'h05 || ir0 !== 1'b0) begin errors++; $display("FAIL s0_stall got ov=%b q=%h ir=%b exp 1 05 0", ov0, q0, ir0); end
        or0 = 1;
        #1;
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL s0_passthru got %b exp 1", ir0); end
        iv0 = 1; id0 = 8'h06;
        tick;
        checks++; if (q0 !== 8'h06 || ov0 !== 1'b1 || occ0 !== 2'd1) begin errors++; $display("FAIL s0_replace got q=%h ov=%b occ=%0d exp 06 1 1", q0, ov0, occ0); end
        iv0 = 0;
        tick;
        checks++; if (ov0 !== 1'b0 || occ0 !== 2'd0) begin errors++; $display("FAIL s0_empty got ov=%b occ=%0d exp 0 0", ov0, occ0); end
        or0 = 0;
    endtask

    task automatic test_soak;
        logic [31:0] e1;
        logic [7:0] e0;
        for (int c = 0; c < 1010; c++) begin
            if (c < 1000) begin
                iv1 = 1'($urandom_range(0, 1)); id1 = $urandom;
                iv0 = 1'($urandom_range(0, 1)); id0 = 8'($urandom);
                or1 = 1'($urandom_range(0, 1)); or0 = 1'($urandom_range(0, 1));
            end else begin
                iv1 = 0; iv0 = 0; or1 = 1; or0 = 1;
            end
            #1;
            checks++; if (qn1 !== ~q1 || qn0 !== ~q0) begin errors++; $display("FAIL soak_qn got qn1=%h q1=%h qn0=%h q0=%h", qn1, q1, qn0, q0); end
            checks++; if (occ0 > 2'd1) begin errors++; $display("FAIL soak_occ0 got %0d exp <=1", occ0); end
            if (ov1 && or1) begin
                e1 = (sb1.size() > 0) ? sb1.pop_front() : 32'hDEAD_BEEF;
                checks++; if (q1 !== e1) begin errors++; $display("FAIL soak_q1 got %h exp %h", q1, e1); end
            end
            if (ov0 && or0) begin
                e0 = (sb0.size() > 0) ? sb0.pop_front() : 8'hEE;
                checks++; if (q0 !== e0) begin errors++; $display("FAIL soak_q0 got %h exp %h", q0, e0); end
            end
            if (iv1 && ir1) sb1.push_back(id1);
            if (iv0 && ir0) sb0.push_back(id0);
            tick;
        end
        checks++; if (sb1.size() != 0 || sb0.size() != 0 || ov1 || ov0) begin errors++; $display("FAIL soak_drain got left1=%0d left0=%0d ov1=%b ov0=%b exp 0", sb1.size(), sb0.size(), ov1, ov0); end
        iv1 = 0; iv0 = 0; or1 = 0; or0 = 0;
    endtask

    initial begin
        test_reset;
        test_streaming;
        test_backpressure;
        test_flush;
        test_skid0;
        test_soak;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
- Parametrised pipeline register with a valid/ready handshake, flush and an optional skid entry. It succeeds the single-bit asynchronous-reset flip-flop.
- Sits between stages of the pipelined MIPS datapath, for example IF/ID and ID/EX. Stages stall through backpressure and squash through flush.
- Provides a registered true output and a complement output. Qn is the exact complement of Q in the same cycle, with no one-cycle lag.

Parameters:
- WIDTH, 32, data width in bits (1..64).
- RESET_VAL, 0 (WIDTH bits), value loaded into all data registers on reset or flush.
- SKID, 1: 1 adds a second (skid) entry and fully registers in_ready; 0 gives a single entry with combinational ready pass-through.

Ports:
- Clk  input  1  clock; all state changes on posedge.
- R  input  1  synchronous active-low reset, sampled on posedge Clk.
- flush  input  1  synchronous squash; empties the block.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  Q holds valid data.
- out_ready  input  1  downstream accepts Q this cycle.
- Q  output  WIDTH  head data (main register).
- Qn  output  WIDTH  bitwise ~Q, combinational from Q.
- occupancy  output  2  number of held entries, 0..2.

Behaviour:
- Handshake rules:
  - Push = in_valid & in_ready at posedge.
  - Pop = out_valid & out_ready at posedge.
  - in_data is sampled only on push. Q changes only on pop, push-into-empty, reset or flush.
- Latency: one cycle. Data pushed at edge N is on Q with out_valid=1 after edge N. No combinational path from in_valid or in_data to out_valid or Q.
- Priority, highest first: reset (R=0), then flush, then push/pop.
- Reset at posedge with R=0:
  - State EMPTY; Q=RESET_VAL; Qn=~RESET_VAL; skid=RESET_VAL.
  - out_valid=0; occupancy=0.
  - in_ready=0 for any cycle where R=0. in_ready=1 in the first cycle after reset is released.
- Flush at posedge with flush=1:
  - Same register effect as reset.
  - in_ready is gated to 0 combinationally while flush=1, so no push can occur in a flush cycle.
  - A pop offered in the same cycle is discarded; the output is squashed.
- States for SKID=1:
  - EMPTY (occ 0, in_ready=1, out_valid=0):
    - push -> ONE, Q<=in_data.
  - ONE (occ 1, in_ready=1, out_valid=1):
    - push & pop -> ONE, Q<=in_data.
    - push only -> TWO, skid<=in_data.
    - pop only -> EMPTY, Q holds its old value.
    - neither -> ONE.
  - TWO (occ 2, in_ready=0, out_valid=1):
    - pop -> ONE, Q<=skid.
    - no pop -> TWO, all registers hold.
  - in_ready is a registered decode of state, with no combinational dependence on out_ready. It is still gated by R and flush.
- States for SKID=0:
  - Only EMPTY and ONE exist; the skid register is not instantiated.
  - in_ready = ~out_valid | out_ready (combinational), gated by R and flush.
  - ONE with push & pop -> ONE, Q<=in_data.
  - occupancy never exceeds 1.
- After a pop to EMPTY, Q retains the last value. Consumers must qualify Q with out_valid.
- Ordering: strictly FIFO, with no data loss or duplication under any in_valid/out_ready pattern.
- Widths: occupancy is zero-extended to 2 bits. Qn equals ~Q bit-for-bit at all times, including in the reset cycle.

Test Plan:
- Reset: WIDTH=32, RESET_VAL=32'h0000_00FF, hold R=0 for 2 cycles.
  - During reset: in_ready=0.
  - After release: Q=32'h0000_00FF, Qn=32'hFFFF_FF00, out_valid=0, occupancy=0, in_ready=1.
- Streaming: SKID=1, out_ready=1, push 1,2,3,4 on consecutive cycles.
  - Q shows 1,2,3,4 one cycle after each push.
  - occupancy stays 1 and in_ready stays 1 throughout.
- Backpressure: SKID=1, out_ready=0, push A then B.
  - After B: occupancy=2, in_ready=0; C is held off.
  - Raise out_ready: Q=A pops, then Q=B; in_ready returns to 1 one cycle after the first pop.
- Flush: SKID=1, state TWO holding A,B; assert flush with in_valid=1, in_data=C.
  - Next cycle: out_valid=0, occupancy=0, Q=RESET_VAL.
  - C was not accepted (in_ready was 0).
- SKID=0 pass-through: out_valid=1, out_ready=0 gives in_ready=0; raising out_ready gives in_ready=1 in the same cycle.
  - Simultaneous push/pop replaces Q with no bubble.
- Randomised stall soak: 1000 random in_valid/out_ready cycles.
  - Output sequence equals input sequence.
  - Qn == ~Q on every cycle.
